// File: rtl/ahb_ram_arbiter.sv
// ahb_ram_arbiter: shares one single-port AHB RAM between master 0 (CPU) and
// master 1 (DMA/debug). Registered round-robin ownership, a burst cap that
// hands the RAM over when the other side is waiting, a lock that suspends the
// cap, and registered read data returned to the owning master.
//
// Handshake: mX_req is the master's valid and mX_gnt is the arbiter's ready.
// A transfer happens in any cycle where both are high; a master that sees
// gnt low must hold req/addr/write/wdata stable until it does see gnt.
module ahb_ram_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [16:2] m0_addr,
  input  logic        m0_write,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [16:2] m1_addr,
  input  logic        m1_write,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic        ram_hsel,
  output logic [16:2] ram_haddr,
  output logic        ram_hwrite,
  output logic [31:0] ram_hwdata,
  input  logic [31:0] ram_hrdata,
  output logic [1:0]  owner
);

  localparam int            CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_CAP = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          cap_hit;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;

  logic          own0, own1;
  logic          xfer0, xfer1;
  logic          owner_req, owner_lock, owner_write, other_req;
  logic [16:2]   owner_addr;
  logic [31:0]   owner_wdata;

  assign own0  = (state_q == ST_OWN0);
  assign own1  = (state_q == ST_OWN1);
  assign xfer0 = own0 & m0_req;
  assign xfer1 = own1 & m1_req;

  // Pick the owning master's request fields; everything is zero while idle.
  always_comb begin
    owner_req   = 1'b0;
    owner_lock  = 1'b0;
    owner_write = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    other_req   = 1'b0;
    if (own0) begin
      owner_req   = m0_req;
      owner_lock  = m0_lock;
      owner_write = m0_write;
      owner_addr  = m0_addr;
      owner_wdata = m0_wdata;
      other_req   = m1_req;
    end else if (own1) begin
      owner_req   = m1_req;
      owner_lock  = m1_lock;
      owner_write = m1_write;
      owner_addr  = m1_addr;
      owner_wdata = m1_wdata;
      other_req   = m0_req;
    end
  end

  // RAM side only sees a selected, non-zero bus during an actual transfer.
  assign ram_hsel   = owner_req;
  assign ram_haddr  = owner_req ? owner_addr : '0;
  assign ram_hwrite = owner_req & owner_write;
  assign ram_hwdata = owner_req ? owner_wdata : '0;

  // Burst count after this cycle's transfer, saturating at the cap.
  assign cnt_inc = (burst_cnt_q == BURST_CAP) ? burst_cnt_q : burst_cnt_q + 1'b1;
  assign cap_hit = (cnt_inc == BURST_CAP);

  // Ownership next state: tie-break on last owner, release, and burst cap.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        if (m0_req && (!m1_req || last_q)) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (m1_req) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!owner_req) begin
          burst_cnt_d = '0;
          if (other_req) begin
            state_d = own0 ? ST_OWN1 : ST_OWN0;
            last_d  = own0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cap_hit && other_req && !owner_lock) begin
          burst_cnt_d = '0;
          state_d     = own0 ? ST_OWN1 : ST_OWN0;
          last_d      = own0;
        end else begin
          burst_cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Read return: capture RAM data at the edge that closes a read transfer.
  always_comb begin
    m0_rvalid_d = xfer0 & ~m0_write;
    m1_rvalid_d = xfer1 & ~m1_write;
    m0_rdata_d  = m0_rvalid_d ? ram_hrdata : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? ram_hrdata : m1_rdata_q;
  end

  // All arbiter state and registered outputs; reset drops any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign m0_gnt    = own0;
  assign m1_gnt    = own1;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign owner     = state_q;

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Bench for ahb_ram_arbiter: per-cycle vector tables with expected owner,
// RAM-side outputs derived from the expected owner, and a read-data
// scoreboard fed from a reference copy of the RAM contents.
module tb_ahb_ram_arbiter;

  localparam logic [1:0] O_I = 2'b00;
  localparam logic [1:0] O_0 = 2'b01;
  localparam logic [1:0] O_1 = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        m0_req, m0_lock, m0_write;
  logic [16:2] m0_addr;
  logic [31:0] m0_wdata;
  logic        m1_req, m1_lock, m1_write;
  logic [16:2] m1_addr;
  logic [31:0] m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_hsel, ram_hwrite;
  logic [16:2] ram_haddr;
  logic [31:0] ram_hwdata, ram_hrdata;
  logic [1:0]  owner;

  logic [31:0] mem     [0:32767];
  logic [31:0] ref_mem [0:32767];

  typedef struct {
    logic        r0, l0, w0;
    logic [14:0] a0;
    logic [31:0] d0;
    logic        r1, l1, w1;
    logic [14:0] a1;
    logic [31:0] d1;
    logic [1:0]  own;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [31:0] last_rd0, last_rd1;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  string       phase    = "init";

  ahb_ram_arbiter #(.MAX_BURST(4)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .m0_req     (m0_req),
    .m0_lock    (m0_lock),
    .m0_addr    (m0_addr),
    .m0_write   (m0_write),
    .m0_wdata   (m0_wdata),
    .m1_req     (m1_req),
    .m1_lock    (m1_lock),
    .m1_addr    (m1_addr),
    .m1_write   (m1_write),
    .m1_wdata   (m1_wdata),
    .m0_gnt     (m0_gnt),
    .m1_gnt     (m1_gnt),
    .m0_rdata   (m0_rdata),
    .m1_rdata   (m1_rdata),
    .m0_rvalid  (m0_rvalid),
    .m1_rvalid  (m1_rvalid),
    .ram_hsel   (ram_hsel),
    .ram_haddr  (ram_haddr),
    .ram_hwrite (ram_hwrite),
    .ram_hwdata (ram_hwdata),
    .ram_hrdata (ram_hrdata),
    .owner      (owner)
  );

  // Clock
  always #5 HCLK = ~HCLK;

  // RAM model: combinational read, write at the edge ending a selected write
  assign ram_hrdata = mem[ram_haddr];
  always @(posedge HCLK) begin
    if (ram_hsel && ram_hwrite) mem[ram_haddr] <= ram_hwdata;
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] <= 32'hA5A5_0000 ^ 32'(i);
    mem[15'h100] <= 32'h1111_1111;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s cycle %0d]: got %h, expected %h", name, phase, cyc, act, exp);
    end
  endtask

  task automatic add(input logic r0, input logic l0, input logic w0,
                     input logic [14:0] a0, input logic [31:0] d0,
                     input logic r1, input logic l1, input logic w1,
                     input logic [14:0] a1, input logic [31:0] d1,
                     input logic [1:0] own);
    vec_t v;
    v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.own = own;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    m0_req = v.r0; m0_lock = v.l0; m0_write = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_lock = v.l1; m1_write = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_owner", 32'(owner), 32'(O_I));
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_ram_hsel", 32'(ram_hsel), 32'd0);
    chk("rst_ram_haddr", 32'(ram_haddr), 32'd0);
    chk("rst_ram_hwrite", 32'(ram_hwrite), 32'd0);
    chk("rst_ram_hwdata", ram_hwdata, 32'd0);
  endtask

  // Scoreboard state follows the reset: in-flight reads are dropped
  task automatic clear_scoreboard();
    exp0_q.delete();
    exp1_q.delete();
    last_rd0 = '0;
    last_rd1 = '0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    clear_inputs();
    clear_scoreboard();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic check_vec(input vec_t v);
    logic        x0, x1;
    logic [14:0] e_addr;
    logic [31:0] e_wdata;
    x0      = (v.own == O_0) && v.r0;
    x1      = (v.own == O_1) && v.r1;
    e_addr  = x0 ? v.a0 : (x1 ? v.a1 : 15'd0);
    e_wdata = x0 ? v.d0 : (x1 ? v.d1 : 32'd0);
    chk("owner", 32'(owner), 32'(v.own));
    chk("m0_gnt", 32'(m0_gnt), 32'(v.own == O_0));
    chk("m1_gnt", 32'(m1_gnt), 32'(v.own == O_1));
    chk("ram_hsel", 32'(ram_hsel), 32'(x0 | x1));
    chk("ram_haddr", 32'(ram_haddr), 32'(e_addr));
    chk("ram_hwrite", 32'(ram_hwrite), 32'((x0 & v.w0) | (x1 & v.w1)));
    chk("ram_hwdata", ram_hwdata, e_wdata);
    // Read returns owed from the previous cycle
    chk("m0_rvalid", 32'(m0_rvalid), 32'(exp0_q.size() != 0));
    if (exp0_q.size() != 0) last_rd0 = exp0_q.pop_front();
    chk("m0_rdata", m0_rdata, last_rd0);
    chk("m1_rvalid", 32'(m1_rvalid), 32'(exp1_q.size() != 0));
    if (exp1_q.size() != 0) last_rd1 = exp1_q.pop_front();
    chk("m1_rdata", m1_rdata, last_rd1);
    // Transfers expected in this cycle
    if (x0) begin
      if (v.w0) ref_mem[v.a0] = v.d0;
      else      exp0_q.push_back(ref_mem[v.a0]);
    end
    if (x1) begin
      if (v.w1) ref_mem[v.a1] = v.d1;
      else      exp1_q.push_back(ref_mem[v.a1]);
    end
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      cyc = i;
      drive(vq[i]);
      @(negedge HCLK);
      check_vec(vq[i]);
      @(posedge HCLK);
      #1;
    end
    vq.delete();
  endtask

  // Owner in cycle k when both masters request continuously from reset
  function automatic logic [1:0] rr_owner(input int k);
    if (k == 0) return O_I;
    return ((((k - 1) / 4) % 2) == 0) ? O_0 : O_1;
  endfunction

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = 32'hA5A5_0000 ^ 32'(i);
    ref_mem[15'h100] = 32'h1111_1111;
    HRESETn = 1'b0;
    clear_inputs();
    clear_scoreboard();

    phase = "reset";
    @(negedge HCLK);
    check_reset_outputs();
    do_reset();

    // Single master write then read back
    phase = "single";
    add(1, 0, 1, 15'h10, 32'hDEAD_BEEF, 0, 0, 0, 15'h0, 32'h0, O_I);
    add(1, 0, 1, 15'h10, 32'hDEAD_BEEF, 0, 0, 0, 15'h0, 32'h0, O_0);
    add(1, 0, 0, 15'h10, 32'h0,         0, 0, 0, 15'h0, 32'h0, O_0);
    add(0, 0, 0, 15'h0,  32'h0,         0, 0, 0, 15'h0, 32'h0, O_0);
    add(0, 0, 0, 15'h0,  32'h0,         0, 0, 0, 15'h0, 32'h0, O_I);
    run_vecs();
    chk("mem_0x10", mem[15'h10], 32'hDEAD_BEEF);

    // Tie after reset, then 4/4 alternation with no idle at handover
    phase = "tie_burst";
    do_reset();
    for (int k = 0; k < 25; k++)
      add(1, 0, 0, 15'(k), 32'h0, 1, 0, 0, 15'(32'h40 + k), 32'h0, rr_owner(k));
    add(0, 0, 0, 15'h0, 32'h0, 0, 0, 0, 15'h0, 32'h0, rr_owner(25));
    add(0, 0, 0, 15'h0, 32'h0, 0, 0, 0, 15'h0, 32'h0, O_I);
    run_vecs();

    // Lock keeps m1 past the cap; dropping it hands over at the next transfer
    phase = "lock";
    do_reset();
    add(0, 0, 0, 15'h0, 32'h0, 1, 1, 1, 15'h200, 32'hB000_0000, O_I);
    for (int k = 1; k <= 10; k++)
      add(1, 0, 0, 15'h10, 32'h0, 1, 1, 1, 15'(32'h200 + k - 1), 32'hB000_0000 + 32'(k), O_1);
    add(1, 0, 0, 15'h10, 32'h0, 1, 0, 1, 15'h20A, 32'hB000_00AA, O_1);
    add(1, 0, 0, 15'h10, 32'h0, 0, 0, 0, 15'h0,   32'h0,         O_0);
    add(0, 0, 0, 15'h0,  32'h0, 0, 0, 0, 15'h0,   32'h0,         O_0);
    add(0, 0, 0, 15'h0,  32'h0, 1, 0, 0, 15'h203, 32'h0,         O_I);
    add(0, 0, 0, 15'h0,  32'h0, 1, 0, 0, 15'h203, 32'h0,         O_1);
    add(0, 0, 0, 15'h0,  32'h0, 0, 0, 0, 15'h0,   32'h0,         O_1);
    add(0, 0, 0, 15'h0,  32'h0, 0, 0, 0, 15'h0,   32'h0,         O_I);
    run_vecs();
    chk("mem_0x20A", mem[15'h20A], 32'hB000_00AA);

    // Release for one cycle, m1 back-to-back reads 0..3, m0 regains after cap
    phase = "release_pipe";
    do_reset();
    add(1, 0, 0, 15'h4, 32'h0, 0, 0, 0, 15'h0, 32'h0, O_I);
    add(1, 0, 0, 15'h4, 32'h0, 0, 0, 0, 15'h0, 32'h0, O_0);
    add(0, 0, 0, 15'h0, 32'h0, 1, 0, 0, 15'h0, 32'h0, O_0);
    add(1, 0, 0, 15'h5, 32'h0, 1, 0, 0, 15'h0, 32'h0, O_1);
    add(1, 0, 0, 15'h5, 32'h0, 1, 0, 0, 15'h1, 32'h0, O_1);
    add(1, 0, 0, 15'h5, 32'h0, 1, 0, 0, 15'h2, 32'h0, O_1);
    add(1, 0, 0, 15'h5, 32'h0, 1, 0, 0, 15'h3, 32'h0, O_1);
    add(1, 0, 0, 15'h5, 32'h0, 0, 0, 0, 15'h0, 32'h0, O_0);
    add(0, 0, 0, 15'h0, 32'h0, 0, 0, 0, 15'h0, 32'h0, O_0);
    add(0, 0, 0, 15'h0, 32'h0, 0, 0, 0, 15'h0, 32'h0, O_I);
    run_vecs();

    // Reset lands in the middle of an m1 write to 0x100
    phase = "reset_mid";
    do_reset();
    add(0, 0, 0, 15'h0, 32'h0, 1, 0, 1, 15'h100, 32'hCAFE_F00D, O_I);
    run_vecs();
    cyc = 1;
    @(negedge HCLK);
    chk("mid_owner", 32'(owner), 32'(O_1));
    chk("mid_ram_hwrite", 32'(ram_hwrite), 32'd1);
    chk("mid_ram_haddr", 32'(ram_haddr), 32'h100);
    #2;
    HRESETn = 1'b0;
    clear_scoreboard();
    #1;
    check_reset_outputs();
    @(posedge HCLK);
    #1;
    chk("mem_0x100_kept", mem[15'h100], 32'h1111_1111);
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 15'h100;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    add(1, 0, 0, 15'h100, 32'h0, 1, 0, 1, 15'h100, 32'hCAFE_F00D, O_I);
    add(1, 0, 0, 15'h100, 32'h0, 1, 0, 1, 15'h100, 32'hCAFE_F00D, O_0);
    add(0, 0, 0, 15'h0,   32'h0, 0, 0, 0, 15'h0,   32'h0,         O_0);
    add(0, 0, 0, 15'h0,   32'h0, 0, 0, 0, 15'h0,   32'h0,         O_I);
    run_vecs();
    chk("mem_0x100_after", mem[15'h100], 32'h1111_1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
